// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - EX-side and MEM-side handshake bundle for ex_mem_stage
interface ex_mem_stage_if #(
    parameter int DATA_W = 32
);
    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_alu_result;
    logic              ex_zero;
    logic [DATA_W-1:0] ex_store_data;
    logic [4:0]        ex_dest_reg;
    logic [15:0]       ex_imm;
    logic [DATA_W-1:0] ex_pc_plus4;
    logic [5:0]        ex_ctrl;

    logic              mem_valid;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_store_data;
    logic [4:0]        mem_dest_reg;
    logic [3:0]        mem_ctrl;
    logic              mem_branch_taken;
    logic [DATA_W-1:0] mem_branch_target;

    // master: the surrounding pipeline (EX producer and MEM consumer)
    modport master (
        output ex_valid, ex_alu_result, ex_zero, ex_store_data, ex_dest_reg,
               ex_imm, ex_pc_plus4, ex_ctrl, mem_ready,
        input  ex_ready, mem_valid, mem_alu_result, mem_store_data,
               mem_dest_reg, mem_ctrl, mem_branch_taken, mem_branch_target
    );

    modport slave (
        input  ex_valid, ex_alu_result, ex_zero, ex_store_data, ex_dest_reg,
               ex_imm, ex_pc_plus4, ex_ctrl, mem_ready,
        output ex_ready, mem_valid, mem_alu_result, mem_store_data,
               mem_dest_reg, mem_ctrl, mem_branch_taken, mem_branch_target
    );
endinterface

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with 2-entry skid buffer and branch resolve
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    ex_mem_stage_if.slave    bus,
    output logic [CNT_W-1:0] stall_count
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] store_data;
        logic [4:0]        dest_reg;
        logic [3:0]        ctrl;
        logic              taken;
        logic [DATA_W-1:0] target;
    } entry_t;

    state_t      state;
    entry_t      main_q;
    entry_t      skid_q;
    entry_t      in_entry;
    logic        mem_valid_q;
    logic        ex_ready_q;
    logic        accept;
    logic        pop;
    logic [DATA_W-1:0] imm_ext;

    always_comb begin
        imm_ext             = {{(DATA_W-16){bus.ex_imm[15]}}, bus.ex_imm};
        in_entry            = '0;
        in_entry.alu_result = bus.ex_alu_result;
        in_entry.store_data = bus.ex_store_data;
        in_entry.dest_reg   = bus.ex_dest_reg;
        in_entry.ctrl       = bus.ex_ctrl[3:0];
        // ex_ctrl[5] = branch, ex_ctrl[4] = branch_ne
        in_entry.taken      = bus.ex_ctrl[5] & (bus.ex_zero ^ bus.ex_ctrl[4]);
        in_entry.target     = bus.ex_pc_plus4 + (imm_ext << 2);
        accept              = bus.ex_valid & ex_ready_q;
        pop                 = mem_valid_q & bus.mem_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            mem_valid_q <= 1'b0;
            ex_ready_q  <= 1'b1;
            stall_count <= '0;
        end else begin
            if (mem_valid_q && !bus.mem_ready && stall_count != {CNT_W{1'b1}})
                stall_count <= stall_count + 1'b1;

            if (flush) begin
                state       <= EMPTY;
                mem_valid_q <= 1'b0;
                ex_ready_q  <= 1'b1;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            main_q      <= in_entry;
                            state       <= ONE;
                            mem_valid_q <= 1'b1;
                        end
                    end
                    ONE: begin
                        if (accept && pop) begin
                            main_q <= in_entry;
                        end else if (accept) begin
                            skid_q     <= in_entry;
                            state      <= TWO;
                            ex_ready_q <= 1'b0;
                        end else if (pop) begin
                            state       <= EMPTY;
                            mem_valid_q <= 1'b0;
                        end
                    end
                    TWO: begin
                        if (pop) begin
                            main_q     <= skid_q;
                            state      <= ONE;
                            ex_ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state       <= EMPTY;
                        mem_valid_q <= 1'b0;
                        ex_ready_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.ex_ready          = ex_ready_q;
    assign bus.mem_valid         = mem_valid_q;
    assign bus.mem_alu_result    = main_q.alu_result;
    assign bus.mem_store_data    = main_q.store_data;
    assign bus.mem_dest_reg      = main_q.dest_reg;
    assign bus.mem_ctrl          = main_q.ctrl;
    assign bus.mem_branch_taken  = main_q.taken & mem_valid_q;
    assign bus.mem_branch_target = main_q.target;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed self-checking bench for ex_mem_stage
module tb_ex_mem_stage;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic [CNT_W-1:0] stall_count;
    int               checks;
    int               failures;

    ex_mem_stage_if #(.DATA_W(DATA_W)) bus ();

    ex_mem_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .bus         (bus.slave),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.ex_valid      = 1'b0;
        bus.ex_alu_result = '0;
        bus.ex_zero       = 1'b0;
        bus.ex_store_data = '0;
        bus.ex_dest_reg   = '0;
        bus.ex_imm        = '0;
        bus.ex_pc_plus4   = '0;
        bus.ex_ctrl       = '0;
        bus.mem_ready     = 1'b1;
        flush             = 1'b0;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [4:0] dest, input logic [5:0] ctrl);
        bus.ex_valid      = 1'b1;
        bus.ex_alu_result = alu;
        bus.ex_store_data = ~alu;
        bus.ex_dest_reg   = dest;
        bus.ex_ctrl       = ctrl;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got %0b want 0", bus.mem_valid); end
        if (bus.ex_ready !== 1'b1) begin failures++; $display("FAIL reset_ex_ready got %0b want 1", bus.ex_ready); end
        if (stall_count !== 4'd0) begin failures++; $display("FAIL reset_stall got %0d want 0", stall_count); end
        if (bus.mem_alu_result !== 32'd0) begin failures++; $display("FAIL reset_alu got %h want 0", bus.mem_alu_result); end
        if (bus.mem_branch_taken !== 1'b0) begin failures++; $display("FAIL reset_taken got %0b want 0", bus.mem_branch_taken); end
    endtask

    task automatic test_basic();
        drive(32'h0000_0010, 5'd5, 6'b000010);
        tick();
        checks += 6;
        if (bus.mem_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got %0b want 1", bus.mem_valid); end
        if (bus.mem_alu_result !== 32'h10) begin failures++; $display("FAIL basic_alu got %h want 10", bus.mem_alu_result); end
        if (bus.mem_dest_reg !== 5'd5) begin failures++; $display("FAIL basic_dest got %0d want 5", bus.mem_dest_reg); end
        if (bus.mem_ctrl !== 4'b0010) begin failures++; $display("FAIL basic_ctrl got %b want 0010", bus.mem_ctrl); end
        if (bus.mem_store_data !== 32'hFFFF_FFEF) begin failures++; $display("FAIL basic_store got %h want ffffffef", bus.mem_store_data); end
        if (bus.ex_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got %0b want 1", bus.ex_ready); end
        bus.ex_valid = 1'b0;
        tick();
        checks += 1;
        if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got %0b want 0", bus.mem_valid); end
    endtask

    task automatic test_branch();
        drive(32'h0, 5'd0, 6'b100000);
        bus.ex_zero     = 1'b1;
        bus.ex_pc_plus4 = 32'h0000_0100;
        bus.ex_imm      = 16'hFFFE;
        tick();
        checks += 2;
        if (bus.mem_branch_taken !== 1'b1) begin failures++; $display("FAIL beq_taken got %0b want 1", bus.mem_branch_taken); end
        if (bus.mem_branch_target !== 32'h0000_00F8) begin failures++; $display("FAIL beq_target got %h want 000000f8", bus.mem_branch_target); end
        bus.ex_ctrl = 6'b110000;
        tick();
        checks += 2;
        if (bus.mem_branch_taken !== 1'b0) begin failures++; $display("FAIL bne_taken got %0b want 0", bus.mem_branch_taken); end
        if (bus.mem_branch_target !== 32'h0000_00F8) begin failures++; $display("FAIL bne_target got %h want 000000f8", bus.mem_branch_target); end
        bus.ex_zero = 1'b0;
        tick();
        checks += 1;
        if (bus.mem_branch_taken !== 1'b1) begin failures++; $display("FAIL bne_nz_taken got %0b want 1", bus.mem_branch_taken); end
        set_idle();
        tick();
        checks += 1;
        if (bus.mem_branch_taken !== 1'b0) begin failures++; $display("FAIL taken_gated got %0b want 0", bus.mem_branch_taken); end
    endtask

    task automatic test_back_to_back();
        bus.mem_ready = 1'b0;
        drive(32'hA, 5'd1, 6'b000010);
        tick();
        checks += 2;
        if (bus.mem_alu_result !== 32'hA) begin failures++; $display("FAIL b2b_a got %h want a", bus.mem_alu_result); end
        if (bus.ex_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got %0b want 1", bus.ex_ready); end
        drive(32'hB, 5'd2, 6'b000010);
        tick();
        checks += 2;
        if (bus.mem_alu_result !== 32'hA) begin failures++; $display("FAIL b2b_a_hold got %h want a", bus.mem_alu_result); end
        if (bus.ex_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready2 got %0b want 0", bus.ex_ready); end
        drive(32'hC, 5'd3, 6'b000010);
        tick();
        checks += 2;
        if (bus.mem_alu_result !== 32'hA) begin failures++; $display("FAIL b2b_a_hold2 got %h want a", bus.mem_alu_result); end
        if (bus.ex_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready3 got %0b want 0", bus.ex_ready); end
        bus.mem_ready = 1'b1;
        tick();
        checks += 3;
        if (bus.mem_alu_result !== 32'hB) begin failures++; $display("FAIL b2b_b got %h want b", bus.mem_alu_result); end
        if (bus.mem_dest_reg !== 5'd2) begin failures++; $display("FAIL b2b_b_dest got %0d want 2", bus.mem_dest_reg); end
        if (bus.ex_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready4 got %0b want 1", bus.ex_ready); end
        tick();
        checks += 2;
        if (bus.mem_alu_result !== 32'hC) begin failures++; $display("FAIL b2b_c got %h want c", bus.mem_alu_result); end
        if (bus.mem_valid !== 1'b1) begin failures++; $display("FAIL b2b_c_valid got %0b want 1", bus.mem_valid); end
        bus.ex_valid = 1'b0;
        tick();
        checks += 1;
        if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got %0b want 0", bus.mem_valid); end
    endtask

    task automatic test_flush();
        bus.mem_ready = 1'b0;
        drive(32'h11, 5'd1, 6'b100000);
        bus.ex_zero = 1'b1;
        tick();
        drive(32'h22, 5'd2, 6'b000010);
        tick();
        checks += 1;
        if (bus.ex_ready !== 1'b0) begin failures++; $display("FAIL flush_pre_two got %0b want 0", bus.ex_ready); end
        drive(32'h33, 5'd3, 6'b000010);
        flush = 1'b1;
        tick();
        checks += 3;
        if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got %0b want 0", bus.mem_valid); end
        if (bus.mem_branch_taken !== 1'b0) begin failures++; $display("FAIL flush_taken got %0b want 0", bus.mem_branch_taken); end
        if (bus.ex_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got %0b want 1", bus.ex_ready); end
        set_idle();
        tick();
        checks += 2;
        if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got %0b want 0", bus.mem_valid); end
        if (bus.ex_ready !== 1'b1) begin failures++; $display("FAIL flush_ready2 got %0b want 1", bus.ex_ready); end
    endtask

    task automatic test_stall();
        do_reset();
        bus.mem_ready = 1'b0;
        drive(32'h55, 5'd7, 6'b000010);
        tick();
        bus.ex_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks += 1;
        if (stall_count !== 4'd5) begin failures++; $display("FAIL stall_5 got %0d want 5", stall_count); end
        for (int i = 0; i < 15; i++) tick();
        checks += 2;
        if (stall_count !== 4'd15) begin failures++; $display("FAIL stall_sat got %0d want 15", stall_count); end
        if (bus.mem_alu_result !== 32'h55) begin failures++; $display("FAIL stall_hold got %h want 55", bus.mem_alu_result); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (stall_count !== 4'd0) begin failures++; $display("FAIL arst_stall got %0d want 0", stall_count); end
        if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got %0b want 0", bus.mem_valid); end
        if (bus.mem_alu_result !== 32'd0) begin failures++; $display("FAIL arst_alu got %h want 0", bus.mem_alu_result); end
        if (bus.mem_dest_reg !== 5'd0) begin failures++; $display("FAIL arst_dest got %0d want 0", bus.mem_dest_reg); end
        if (bus.ex_ready !== 1'b1) begin failures++; $display("FAIL arst_ready got %0b want 1", bus.ex_ready); end
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        set_idle();
        test_reset();
        test_basic();
        test_branch();
        test_back_to_back();
        test_flush();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
